// File: rtl/lr35902_lcd_fb.sv
// Pixel sink behind the LR35902 PPU. Packs 2-bit shades four to a byte, queues the
// bytes and writes them into a double-buffered framebuffer, swapping banks per frame.
module lr35902_lcd_fb #(
  parameter int FIFO_DEPTH = 4,
  parameter int LINE_PX    = 160,
  parameter int LINES      = 144
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        disp_on,
  input  logic        px_out,
  input  logic [1:0]  px,
  output logic        fb_write,
  output logic [13:0] fb_adr,
  output logic [7:0]  fb_dout,
  input  logic        fb_ack,
  output logic        front_bank,
  output logic        frame_done,
  output logic        overflow
);

  localparam int XW = $clog2(LINE_PX);
  localparam int YW = $clog2(LINES);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [XW-1:0] X_LAST   = XW'(LINE_PX - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(LINES - 1);
  localparam logic [12:0]   OFF_LAST = 13'(LINE_PX * LINES / 4 - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic        bank;
    logic        last;
    logic [12:0] off;
    logic [7:0]  data;
  } entry_t;

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [12:0]   off_q, off_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [5:0]    shift_q, shift_d;
  logic          wbank_q, wbank_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  entry_t        head_q, head_d;
  logic          fb_write_q, fb_write_d;
  logic          front_q, front_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;

  entry_t        mem [FIFO_DEPTH];
  entry_t        new_entry;
  logic          push, push_ok, pop;

  // NOTE: every signal assigned here gets a default first, otherwise a latch is inferred.
  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    off_d     = off_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    wbank_d   = wbank_q;
    front_d   = front_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;
    push      = 1'b0;
    new_entry = '0;
    pop       = fb_write_q & fb_ack;

    if (!disp_on) begin
      x_d     = '0;
      y_d     = '0;
      off_d   = '0;
      cnt_d   = '0;
      shift_d = '0;
    end else if (px_out) begin
      x_d     = (x_q == X_LAST) ? '0 : x_q + XW'(1);
      if (x_q == X_LAST) y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
      cnt_d   = cnt_q + 2'd1;
      shift_d = {shift_q[3:0], px};
      if (cnt_q == 2'd3) begin
        push           = 1'b1;
        new_entry.bank = wbank_q;
        new_entry.last = (off_q == OFF_LAST);
        new_entry.off  = off_q;
        new_entry.data = {shift_q, px};
        off_d          = (off_q == OFF_LAST) ? '0 : off_q + 13'd1;
      end
    end

    // The swap follows the bank tag of the acked entry; a frame-end pack flips the
    // write bank immediately so bytes of the next frame queue up with the new tag.
    if (pop && head_q.last) begin
      front_d = head_q.bank;
      done_d  = 1'b1;
      wbank_d = ~head_q.bank;
    end
    if (push && new_entry.last) wbank_d = ~wbank_q;

    push_ok = push && ((count_q != DEPTH_C) || pop);
    if (push && !push_ok) ovf_d = 1'b1;

    rd_ptr_d   = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    count_d    = count_q + CW'(push_ok) - CW'(pop);
    fb_write_d = (count_d != '0);

    // Bypass the RAM when the pushed byte becomes the new head in the same edge.
    head_d = head_q;
    if (count_d != '0)
      head_d = (push_ok && (count_q - CW'(pop)) == '0) ? new_entry : mem[rd_ptr_d];
  end

  // NOTE: FIFO storage has no reset; count and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= new_entry;
  end

  // NOTE: state flops use non-blocking assignments so all update from the same old values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q        <= '0;
      y_q        <= '0;
      off_q      <= '0;
      cnt_q      <= '0;
      shift_q    <= '0;
      wbank_q    <= 1'b1;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      head_q     <= '0;
      fb_write_q <= 1'b0;
      front_q    <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      off_q      <= off_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      wbank_q    <= wbank_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      head_q     <= head_d;
      fb_write_q <= fb_write_d;
      front_q    <= front_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  assign fb_write   = fb_write_q;
  assign fb_adr     = {head_q.bank, head_q.off};
  assign fb_dout    = head_q.data;
  assign front_bank = front_q;
  assign frame_done = done_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_lr35902_lcd_fb.sv
// Scoreboard bench for lr35902_lcd_fb: a pixel-level model predicts every RAM write,
// and a negedge monitor pops and compares each acknowledged transfer.
module tb_lr35902_lcd_fb;

  localparam int FIFO_DEPTH = 4;
  localparam int FRAME_PX   = 160 * 144;
  localparam int LAST_OFF   = FRAME_PX / 4 - 1;

  logic        clk = 1'b0;
  logic        reset, disp_on, px_out, fb_ack;
  logic [1:0]  px;
  logic        fb_write, front_bank, frame_done, overflow;
  logic [13:0] fb_adr;
  logic [7:0]  fb_dout;

  lr35902_lcd_fb #(.FIFO_DEPTH(FIFO_DEPTH), .LINE_PX(160), .LINES(144)) dut (
    .clk(clk), .reset(reset), .disp_on(disp_on), .px_out(px_out), .px(px),
    .fb_write(fb_write), .fb_adr(fb_adr), .fb_dout(fb_dout), .fb_ack(fb_ack),
    .front_bank(front_bank), .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] adr;
    logic [7:0]  dout;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_writes = 0;
  int          fd_cnt   = 0;

  int          m_off;
  int          m_cnt;
  logic [7:0]  m_shift;
  logic        m_bank;
  logic        m_front;
  logic        sb_drop;
  logic        mon_en;
  logic        swap_pend, swap_bank, prev_stall;
  logic [13:0] prev_adr;
  logic [7:0]  prev_dout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_off   = 0;
    m_cnt   = 0;
    m_shift = '0;
  endtask

  task automatic put_px(input logic [1:0] s);
    px_out = 1'b1;
    px     = s;
    @(posedge clk);
    #1;
    px_out = 1'b0;
    m_shift = {m_shift[5:0], s};
    m_cnt++;
    if (m_cnt == 4) begin
      m_cnt = 0;
      if (!sb_drop)
        sb.push_back('{adr: {m_bank, 13'(m_off)}, dout: m_shift, last: (m_off == LAST_OFF)});
      if (m_off == LAST_OFF) begin
        m_bank = ~m_bank;
        m_off  = 0;
      end else begin
        m_off++;
      end
    end
  endtask

  task automatic feed_frame(input int from, input int to);
    for (int i = from; i < to; i++) put_px(2'(i % 160));
  endtask

  task automatic disp_low();
    disp_on = 1'b0;
    @(posedge clk);
    #1;
    disp_on = 1'b1;
    model_clear();
  endtask

  task automatic wait_drain(input int max_cycles);
    int i;
    i = 0;
    while ((sb.size() != 0 || fb_write) && i < max_cycles) begin
      @(posedge clk);
      #1;
      i++;
    end
    check("drain", 32'(sb.size() == 0 && !fb_write), 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      check("frame_done", 32'(frame_done), 32'(swap_pend));
      if (frame_done) fd_cnt++;
      if (swap_pend) m_front = swap_bank;
      swap_pend = 1'b0;
      check("front_bank", 32'(front_bank), 32'(m_front));
      if (prev_stall) begin
        check("hold_write", 32'(fb_write), 32'd1);
        check("hold_adr", 32'(fb_adr), 32'(prev_adr));
        check("hold_dout", 32'(fb_dout), 32'(prev_dout));
      end
      if (fb_write && fb_ack) begin
        check("write_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("fb_adr", 32'(fb_adr), 32'(e.adr));
          check("fb_dout", 32'(fb_dout), 32'(e.dout));
          if (e.last) begin
            swap_pend = 1'b1;
            swap_bank = e.adr[13];
          end
        end
        n_writes++;
      end
      prev_stall = fb_write && !fb_ack;
      prev_adr   = fb_adr;
      prev_dout  = fb_dout;
    end else begin
      swap_pend  = 1'b0;
      prev_stall = 1'b0;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; disp_on = 1'b0; px_out = 1'b0; px = 2'd0; fb_ack = 1'b0;
    mon_en = 1'b0; sb_drop = 1'b0; swap_pend = 1'b0; swap_bank = 1'b0;
    prev_stall = 1'b0; prev_adr = '0; prev_dout = '0;
    m_bank = 1'b1; m_front = 1'b0;
    model_clear();

    repeat (2) @(posedge clk);
    #1;
    check("rst_fb_write", 32'(fb_write), 32'd0);
    check("rst_fb_adr", 32'(fb_adr), 32'd0);
    check("rst_fb_dout", 32'(fb_dout), 32'd0);
    check("rst_front_bank", 32'(front_bank), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b1;
    disp_on = 1'b1;
    mon_en = 1'b1;

    // First byte: shades 3,2,1,0 land at bank 1, offset 0.
    fb_ack = 1'b1;
    put_px(2'd3); put_px(2'd2); put_px(2'd1); put_px(2'd0);
    check("first_byte_queued", 32'(sb.size() == 1 && sb[0].adr == 14'h2000 && sb[0].dout == 8'hE4), 32'd1);
    wait_drain(50);
    disp_low();

    // Stalled RAM: the fifth byte has nowhere to go.
    fb_ack = 1'b0;
    for (int i = 0; i < 4 * (FIFO_DEPTH + 1); i++) begin
      sb_drop = (i >= 4 * FIFO_DEPTH);
      put_px(2'($urandom_range(3)));
    end
    sb_drop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_write_pending", 32'(fb_write), 32'd1);
    check("ovf_head_adr", 32'(fb_adr), 32'h2000);
    check("ovf_pending_count", 32'(sb.size()), 32'(FIFO_DEPTH));
    n_writes = 0;
    fb_ack = 1'b1;
    wait_drain(50);
    check("ovf_write_count", 32'(n_writes), 32'(FIFO_DEPTH));
    check("ovf_sticky", 32'(overflow), 32'd1);
    disp_low();

    // Display off mid-byte discards the partial byte and restarts at offset 0.
    for (int i = 0; i < 82; i++) put_px(2'($urandom_range(3)));
    disp_low();
    for (int i = 0; i < 80; i++) put_px(2'($urandom_range(3)));
    wait_drain(100);

    // Fourth pixel on the same edge as disp_on falling is dropped.
    put_px(2'd1); put_px(2'd1); put_px(2'd1);
    px_out = 1'b1; px = 2'd2; disp_on = 1'b0;
    @(posedge clk);
    #1;
    px_out = 1'b0; disp_on = 1'b1;
    model_clear();
    put_px(2'd0); put_px(2'd3); put_px(2'd0); put_px(2'd3);
    wait_drain(50);
    check("no_swap_yet", 32'(fd_cnt), 32'd0);
    disp_low();

    // Full frame into bank 1.
    n_writes = 0;
    feed_frame(0, FRAME_PX);
    wait_drain(100);
    check("frame1_writes", 32'(n_writes), 32'(LAST_OFF + 1));
    check("frame1_front", 32'(front_bank), 32'd1);
    check("frame1_pulses", 32'(fd_cnt), 32'd1);

    // Second frame into bank 0; its last byte stalls while the next frame starts.
    feed_frame(0, FRAME_PX - 4);
    repeat (4) @(posedge clk);
    #1;
    fb_ack = 1'b0;
    feed_frame(FRAME_PX - 4, FRAME_PX);
    feed_frame(0, 4);
    repeat (6) @(posedge clk);
    #1;
    check("stall_write", 32'(fb_write), 32'd1);
    check("stall_last_adr", 32'(fb_adr), 32'(LAST_OFF));
    check("stall_next_tag", 32'(sb.size() == 2 && sb[1].adr == 14'h2000), 32'd1);
    check("stall_no_swap", 32'(fd_cnt), 32'd1);
    check("stall_front", 32'(front_bank), 32'd1);
    fb_ack = 1'b1;
    wait_drain(50);
    check("frame2_front", 32'(front_bank), 32'd0);
    check("frame2_pulses", 32'(fd_cnt), 32'd2);

    // Asynchronous reset during a pending write.
    fb_ack = 1'b0;
    put_px(2'd2); put_px(2'd2); put_px(2'd2); put_px(2'd2);
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_write", 32'(fb_write), 32'd1);
    mon_en = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("async_fb_write", 32'(fb_write), 32'd0);
    check("async_fb_adr", 32'(fb_adr), 32'd0);
    check("async_fb_dout", 32'(fb_dout), 32'd0);
    check("async_front", 32'(front_bank), 32'd0);
    check("async_done", 32'(frame_done), 32'd0);
    check("async_overflow", 32'(overflow), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    model_clear();
    m_bank = 1'b1;
    m_front = 1'b0;
    mon_en = 1'b1;

    fb_ack = 1'b1;
    put_px(2'd3); put_px(2'd2); put_px(2'd1); put_px(2'd0);
    wait_drain(50);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
